// File: rtl/shiftreg_param.sv
`default_nettype none
// ============================================================================
// Module   : shiftreg_param
// Purpose  : Parameterised shift/rotate register with a small IDLE/RUN/DONE
//            controller. Single-cycle ops (set, load, clear) complete at the
//            accepting edge. Shift and rotate ops step one bit per clock for
//            'amt' cycles.
// Ports    : clk    - clock, rising-edge active
//            rst    - asynchronous active-high reset
//            start  - begin an operation (accepted in IDLE only)
//            op     - operation code (see c_OP_* below)
//            amt    - shift/rotate step count, 0..WIDTH-1
//            datain - parallel load data
//            sin    - serial fill bit for shift-left, sampled on every step
//            out    - register contents
//            sout   - last bit shifted or rotated out
//            busy   - high while a multi-step operation runs
//            done   - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module shiftreg_param #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] datain,
  input  logic             sin,
  output logic [WIDTH-1:0] out,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] c_OP_SET  = 3'b000;
  localparam logic [2:0] c_OP_SHL  = 3'b001;
  localparam logic [2:0] c_OP_ROL  = 3'b010;
  localparam logic [2:0] c_OP_SHR  = 3'b011;
  localparam logic [2:0] c_OP_SAR  = 3'b100;
  localparam logic [2:0] c_OP_ROR  = 3'b101;
  localparam logic [2:0] c_OP_LOAD = 3'b110;
  localparam logic [2:0] c_OP_CLR  = 3'b111;

  localparam logic [AMT_W-1:0] c_CNT_ONE = AMT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   out_q;
  logic               sout_q;
  logic [2:0]         op_q;
  logic [AMT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;

  // Result of one single-bit step of the latched op.
  logic [WIDTH-1:0]   step_d;
  logic               step_sout_d;

  always_comb begin
    step_d      = out_q;
    step_sout_d = sout_q;
    case (op_q)
      c_OP_SHL: begin
        step_d      = {out_q[WIDTH-2:0], sin};
        step_sout_d = out_q[WIDTH-1];
      end
      c_OP_ROL: begin
        step_d      = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        step_sout_d = out_q[WIDTH-1];
      end
      c_OP_SHR: begin
        step_d      = {1'b0, out_q[WIDTH-1:1]};
        step_sout_d = out_q[0];
      end
      c_OP_SAR: begin
        step_d      = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
        step_sout_d = out_q[0];
      end
      c_OP_ROR: begin
        step_d      = {out_q[0], out_q[WIDTH-1:1]};
        step_sout_d = out_q[0];
      end
      default: begin
        step_d      = out_q;
        step_sout_d = sout_q;
      end
    endcase
  end

  // busy/done are registered alongside the state so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      sout_q  <= 1'b0;
      op_q    <= c_OP_SET;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              c_OP_SET, c_OP_LOAD, c_OP_CLR: begin
                if (op == c_OP_SET) begin
                  out_q <= '1;
                end else if (op == c_OP_LOAD) begin
                  out_q <= datain;
                end else begin
                  out_q <= '0;
                end
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
              default: begin
                // Latch op/amt so input changes during RUN have no effect.
                op_q    <= op;
                cnt_q   <= amt;
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
              end
            endcase
          end
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            out_q  <= step_d;
            sout_q <= step_sout_d;
            cnt_q  <= cnt_q - c_CNT_ONE;
          end
          // amt=0 still spends one RUN cycle, then completes unchanged.
          if (cnt_q == '0 || cnt_q == c_CNT_ONE) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftreg_param
// Purpose  : Scoreboard bench for shiftreg_param (WIDTH=8). Stimulus pushes
//            the expected observation for every cycle in which busy or done
//            is high; a monitor pops and compares on each falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftreg_param;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [2:0] amt;
  logic [7:0] datain;
  logic       sin;
  logic [7:0] out;
  logic       sout;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] o;
    logic       s;
    logic       b;
    logic       d;
  } exp_t;

  exp_t sb_q[$];

  shiftreg_param #(.WIDTH(8), .AMT_W(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .amt    (amt),
    .datain (datain),
    .sin    (sin),
    .out    (out),
    .sout   (sout),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [7:0] o, input logic s, input logic b, input logic d);
    exp_t e;
    e.o = o; e.s = s; e.b = b; e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with busy or done high must match the next entry.
  always @(negedge clk) begin
    if (!rst && (busy || done)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: unexpected output out=%h sout=%b busy=%b done=%b", out, sout, busy, done);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (out !== e.o || sout !== e.s || busy !== e.b || done !== e.d) begin
          errors++;
          $display("FAIL monitor: out=%h sout=%b busy=%b done=%b, expected out=%h sout=%b busy=%b done=%b",
                   out, sout, busy, done, e.o, e.s, e.b, e.d);
        end
      end
    end
  end

  // Issue one operation, scramble op/amt/datain after acceptance, and wait
  // (bounded) for the done pulse.
  task automatic do_op(input logic [2:0] o, input logic [2:0] a, input logic [7:0] d, input logic s);
    bit got;
    @(posedge clk); #1;
    start = 1'b1; op = o; amt = a; datain = d; sin = s;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b110; amt = 3'd7; datain = 8'h00;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: op=%b done never seen", o);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 3'b000; amt = 3'd0; datain = 8'h00; sin = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset_out",  out, 8'h00);
    chk("reset_flags", {5'd0, sout, busy, done}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Load A5
    push(8'hA5, 1'b0, 1'b0, 1'b1);
    do_op(3'b110, 3'd0, 8'hA5, 1'b0);
    chk("load_out", out, 8'hA5);

    // Arithmetic shift right by 3
    push(8'hA5, 1'b0, 1'b1, 1'b0);
    push(8'hD2, 1'b1, 1'b1, 1'b0);
    push(8'hE9, 1'b0, 1'b1, 1'b0);
    push(8'hF4, 1'b1, 1'b0, 1'b1);
    do_op(3'b100, 3'd3, 8'h00, 1'b0);

    // Shift left by 2 with sin=1 from 81
    push(8'h81, 1'b1, 1'b0, 1'b1);
    do_op(3'b110, 3'd0, 8'h81, 1'b0);
    push(8'h81, 1'b1, 1'b1, 1'b0);
    push(8'h03, 1'b1, 1'b1, 1'b0);
    push(8'h07, 1'b0, 1'b0, 1'b1);
    do_op(3'b001, 3'd2, 8'h00, 1'b1);

    // Rotate left by 4 from 3C, then rotate right by 0
    push(8'h3C, 1'b0, 1'b0, 1'b1);
    do_op(3'b110, 3'd0, 8'h3C, 1'b0);
    push(8'h3C, 1'b0, 1'b1, 1'b0);
    push(8'h78, 1'b0, 1'b1, 1'b0);
    push(8'hF0, 1'b0, 1'b1, 1'b0);
    push(8'hE1, 1'b1, 1'b1, 1'b0);
    push(8'hC3, 1'b1, 1'b0, 1'b1);
    do_op(3'b010, 3'd4, 8'h00, 1'b0);
    push(8'hC3, 1'b1, 1'b1, 1'b0);
    push(8'hC3, 1'b1, 1'b0, 1'b1);
    do_op(3'b101, 3'd0, 8'h00, 1'b0);

    // Set all ones, clear, then rotate right by 2 from 96
    push(8'hFF, 1'b1, 1'b0, 1'b1);
    do_op(3'b000, 3'd0, 8'h00, 1'b0);
    push(8'h00, 1'b1, 1'b0, 1'b1);
    do_op(3'b111, 3'd0, 8'h00, 1'b0);
    push(8'h96, 1'b1, 1'b0, 1'b1);
    do_op(3'b110, 3'd0, 8'h96, 1'b0);
    push(8'h96, 1'b1, 1'b1, 1'b0);
    push(8'h4B, 1'b0, 1'b1, 1'b0);
    push(8'hA5, 1'b1, 1'b0, 1'b1);
    do_op(3'b101, 3'd2, 8'h00, 1'b0);

    // Logical shift right with ignored start during RUN, then abort by reset
    push(8'h81, 1'b1, 1'b0, 1'b1);
    do_op(3'b110, 3'd0, 8'h81, 1'b0);
    push(8'h81, 1'b1, 1'b1, 1'b0);
    push(8'h40, 1'b1, 1'b1, 1'b0);
    push(8'h20, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; op = 3'b011; amt = 3'd5; datain = 8'h00;
    @(posedge clk); #1;
    start = 1'b1; op = 3'b110; amt = 3'd7; datain = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_out",   out, 8'h00);
    chk("abort_flags", {5'd0, sout, busy, done}, 8'h00);
    chk("abort_sb_empty", 8'(sb_q.size()), 8'd0);
    start = 1'b1; op = 3'b110; datain = 8'h5A;
    @(posedge clk); #1;
    chk("start_in_reset", out, 8'h00);
    rst = 1'b0;
    push(8'h5A, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_reset_load", out, 8'h5A);
    repeat (5) @(posedge clk);
    #1;
    chk("final_sb_empty", 8'(sb_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shiftreg_param.md
SHIFTREG_PARAM -- requirements
Module: shiftreg_param

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning register width in bits; legal values 4..64, power of two.
REQ-002 The module SHALL have parameter AMT_W, default 3, meaning shift-amount width; the integrator SHALL set AMT_W to log2(WIDTH).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 The module SHALL have port op, input, 3 bits: operation code.
REQ-007 The module SHALL have port amt, input, AMT_W bits: shift/rotate step count, 0..WIDTH-1.
REQ-008 The module SHALL have port datain, input, WIDTH bits: parallel load data.
REQ-009 The module SHALL have port sin, input, 1 bit: serial fill bit for shift-left.
REQ-010 The module SHALL have port out, output, WIDTH bits: register contents.
REQ-011 The module SHALL have port sout, output, 1 bit: last bit shifted or rotated out.
REQ-012 The module SHALL have port busy, output, 1 bit: high while a multi-step operation runs.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 The op encoding SHALL be: 000 set all ones; 001 shift left with sin fill; 010 rotate left; 011 shift right logical (zero fill); 100 shift right arithmetic (MSB replicated); 101 rotate right; 110 parallel load datain; 111 clear.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE.
REQ-016 start SHALL be accepted only in IDLE; start in RUN or DONE SHALL be ignored without being queued.
REQ-017 At the accepting edge of op 000, 110 or 111, the module SHALL update out (datain sampled at that edge) and go to DONE.
REQ-018 At the accepting edge of ops 001-101, the module SHALL latch op and amt and load the step counter with amt, SHALL leave out unchanged, and SHALL go to RUN.
REQ-019 On each RUN edge with counter nonzero, the module SHALL perform a one-bit step of the latched op, SHALL decrement the counter, and SHALL go to DONE when the counter goes 1 to 0.
REQ-020 On a RUN edge with counter zero (amt=0), the module SHALL go to DONE with out and sout unchanged.
REQ-021 Latency SHALL be: a shift op with amt=n accepted at edge k has its final out after edge k+n, done high in the following cycle, and busy high for max(n,1) cycles.
REQ-022 sin SHALL be sampled live on every shift-left step and SHALL NOT be latched.
REQ-023 Changes to op, amt and datain during RUN or DONE SHALL NOT affect the operation in progress.
REQ-024 sout SHALL update on each step: the pre-step MSB for ops 001/010, and the pre-step LSB for ops 011/100/101.
REQ-025 sout SHALL hold its value on ops 000, 110 and 111.
REQ-026 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-027 A new start may therefore be accepted no sooner than two edges after the previous completion edge.
REQ-028 Rotates SHALL be lossless: WIDTH steps would reproduce the original value, although amt is capped at WIDTH-1.

Reset
REQ-029 While rst is high, the module SHALL immediately force out=0, sout=0, busy=0, done=0, state IDLE and counter 0, independent of clk.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-031 start SHALL be ignored while rst is high, and the first edge after release SHALL be able to accept start.

Verification (WIDTH=8)
REQ-032 The bench SHALL check reset: assert rst mid-cycle -> out=00, sout=0, busy=0, done=0 before the next clk edge.
REQ-033 The bench SHALL check load: start with op=110, datain=A5 -> out=A5 after the accepting edge, done high one cycle, busy never high.
REQ-034 The bench SHALL check arithmetic shift: from A5, start with op=100, amt=3 -> out D2, E9, F4 on successive RUN edges; busy high 3 cycles; final sout=1; done one cycle.
REQ-035 The bench SHALL check shift left: from 81, start with op=001, amt=2, sin=1 -> out 03 with sout=1, then 07 with sout=0.
REQ-036 The bench SHALL check rotate and zero amount: from 3C, op=010, amt=4 -> C3; then op=101, amt=0 -> out stays C3, busy one cycle, done pulse.
REQ-037 The bench SHALL check ignored start and abort: start pulsed during RUN is ignored; rst during RUN of op 011 -> out=00 and no done pulse.
